// File: rtl/core_seq_pkg.sv
// Shared types and inst-word layout for the core instruction sequencer.
package core_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_W_L0, S_W_LOAD, S_W_GAP, S_A_L0, S_A_GAP,
        S_EXEC, S_DRAIN, S_OREAD, S_NEXT, S_DONE
    } state_t;

    localparam int INST_W = 52;

    localparam int B_CEN_O      = 50;
    localparam int B_WEN_O      = 49;
    localparam int A_OMEM_LSB   = 38;
    localparam int B_L0_RD_MODE = 36;
    localparam int B_MODE       = 35;
    localparam int B_DATA_MODE  = 34;
    localparam int B_CEN_P      = 32;
    localparam int B_WEN_P      = 31;
    localparam int A_PMEM_LSB   = 20;
    localparam int B_CEN_X      = 19;
    localparam int B_WEN_X      = 18;
    localparam int A_XMEM_LSB   = 7;
    localparam int B_OFIFO_RD   = 6;
    localparam int B_L0_RD      = 3;
    localparam int B_L0_WR      = 2;
    localparam int B_EXEC       = 1;
    localparam int B_LOAD       = 0;

    // All memories deselected, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 52'h6_0001_800C_0000;

endpackage

// File: rtl/core_seq_inst_enc.sv
// Combinational encoder: (state, phase, kij, bases) -> next inst word for core.
module core_seq_inst_enc
    import core_seq_pkg::*;
#(
    parameter int AW  = 11,
    parameter int COL = 8
) (
    input  state_t              state,
    input  logic [AW:0]         phase,
    input  logic [3:0]          kij,
    input  logic [AW-1:0]       len_nij,
    input  logic [AW-1:0]       x_base,
    input  logic [AW-1:0]       w_base,
    input  logic [AW-1:0]       o_base,
    output logic [INST_W-1:0]   inst
);

    logic [AW-1:0] ph, w_addr, x_addr, o_addr;

    always_comb begin
        ph     = phase[AW-1:0];
        w_addr = w_base + AW'(kij) * AW'(COL) + ph;
        x_addr = x_base + ph;
        // OREAD writes lag the FIFO pop by one cycle, hence the -1.
        o_addr = o_base + AW'(kij) * len_nij + ph - AW'(1);
        inst   = INST_IDLE;
        case (state)
            S_W_L0: begin
                inst[B_MODE]      = 1'b1;
                inst[B_DATA_MODE] = 1'b1;
                inst[B_CEN_P]     = 1'b0;
                inst[B_L0_WR]     = 1'b1;
                inst[A_PMEM_LSB +: AW] = w_addr;
            end
            S_W_LOAD: begin
                inst[B_L0_RD]      = 1'b1;
                inst[B_L0_RD_MODE] = 1'b1;
                inst[B_LOAD]       = 1'b1;
            end
            S_W_GAP: begin
                inst[B_MODE]      = 1'b1;
                inst[B_DATA_MODE] = 1'b1;
            end
            S_A_L0: begin
                inst[B_MODE]  = 1'b1;
                inst[B_CEN_X] = 1'b0;
                inst[B_L0_WR] = 1'b1;
                inst[A_XMEM_LSB +: AW] = x_addr;
            end
            S_A_GAP: inst[B_MODE] = 1'b1;
            S_EXEC: begin
                inst[B_L0_RD] = 1'b1;
                inst[B_LOAD]  = 1'b1;
                inst[B_EXEC]  = 1'b1;
            end
            S_OREAD: begin
                if (phase < {1'b0, len_nij}) inst[B_OFIFO_RD] = 1'b1;
                if (phase != '0) begin
                    inst[B_CEN_O] = 1'b0;
                    inst[B_WEN_O] = 1'b0;
                    inst[A_OMEM_LSB +: AW] = o_addr;
                end
            end
            default: inst = INST_IDLE;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Weight-stationary conv pass sequencer driving core.inst.
// Optional CORE_SEQ_DRAIN_ON_VALID_EN: DRAIN ends early on ofifo_valid.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int AW        = 11,
    parameter int COL       = 8,
    parameter int GAP_CYC   = 10,
    parameter int DRAIN_CYC = 35
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        num_kij,
    input  logic [AW-1:0]     len_nij,
    input  logic [AW-1:0]     x_base,
    input  logic [AW-1:0]     w_base,
    input  logic [AW-1:0]     o_base,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    state_t              state;
    logic [AW:0]         phase, lim;
    logic [3:0]          kij, nk_r;
    logic [AW-1:0]       len_r, xb_r, wb_r, ob_r;
    logic                last, drain_exit;
    logic [INST_W-1:0]   enc_inst;

    always_comb begin
        lim = (AW+1)'(1);
        case (state)
            S_W_L0, S_W_LOAD: lim = (AW+1)'(COL);
            S_W_GAP, S_A_GAP: lim = (AW+1)'(GAP_CYC);
            S_A_L0, S_EXEC:   lim = {1'b0, len_r};
            S_DRAIN:          lim = (AW+1)'(DRAIN_CYC);
            S_OREAD:          lim = {1'b0, len_r} + 1'b1;
            default:          lim = (AW+1)'(1);
        endcase
        last = (phase + 1'b1) == lim;
    end

`ifdef CORE_SEQ_DRAIN_ON_VALID_EN
    assign drain_exit = last | ofifo_valid;
`else
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = ofifo_valid;
    assign drain_exit = last;
`endif

    core_seq_inst_enc #(.AW(AW), .COL(COL)) u_enc (
        .state   (state),
        .phase   (phase),
        .kij     (kij),
        .len_nij (len_r),
        .x_base  (xb_r),
        .w_base  (wb_r),
        .o_base  (ob_r),
        .inst    (enc_inst)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            phase <= '0;
            kij   <= '0;
            nk_r  <= '0;
            len_r <= '0;
            xb_r  <= '0;
            wb_r  <= '0;
            ob_r  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            inst  <= INST_IDLE;
        end else begin
            inst  <= enc_inst;
            done  <= 1'b0;
            phase <= phase + 1'b1;
            case (state)
                S_IDLE: begin
                    phase <= '0;
                    if (start) begin
                        nk_r  <= num_kij;
                        len_r <= len_nij;
                        xb_r  <= x_base;
                        wb_r  <= w_base;
                        ob_r  <= o_base;
                        kij   <= '0;
                        // Degenerate pass: straight to DONE with no memory traffic.
                        if (num_kij == '0 || len_nij == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_W_L0;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_W_L0:   if (last) begin state <= S_W_LOAD; phase <= '0; end
                S_W_LOAD: if (last) begin state <= S_W_GAP;  phase <= '0; end
                S_W_GAP:  if (last) begin state <= S_A_L0;   phase <= '0; end
                S_A_L0:   if (last) begin state <= S_A_GAP;  phase <= '0; end
                S_A_GAP:  if (last) begin state <= S_EXEC;   phase <= '0; end
                S_EXEC:   if (last) begin state <= S_DRAIN;  phase <= '0; end
                S_DRAIN:  if (drain_exit) begin state <= S_OREAD; phase <= '0; end
                S_OREAD:  if (last) begin state <= S_NEXT;   phase <= '0; end
                S_NEXT: begin
                    phase <= '0;
                    kij   <= kij + 1'b1;
                    if (kij + 1'b1 == nk_r) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_W_L0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    phase <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    phase <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: field-level checks on the inst stream.
module tb_core_sequencer;

    localparam int AW = 11;
    localparam logic [51:0] IDLE_W = 52'h6_0001_800C_0000;
`ifdef CORE_SEQ_DRAIN_ON_VALID_EN
    localparam int EXP_GAP_V  = 7;
    localparam int EXP_BUSY_V = 56;
`else
    localparam int EXP_GAP_V  = 36;
    localparam int EXP_BUSY_V = 85;
`endif

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
    logic [3:0]    num_kij = '0;
    logic [AW-1:0] len_nij = '0, x_base = '0, w_base = '0, o_base = '0;
    logic [51:0]   inst;
    logic          busy, done;

    int vecs = 0, errs = 0;
    int busy_cyc, done_cnt, done_cyc, cen_low;
    int pmem_n, pmem_first, first_pmem, pmem_bad;
    int xmem_n, xmem_bad, load_n, exec_n, last_exec, first_rd;
    int omem_n, omem_bad, omem_last, omem_288, first_omem;

    always #5 clk = ~clk;

    core_sequencer #(.AW(AW), .COL(8), .GAP_CYC(10), .DRAIN_CYC(35)) dut (
        .clk(clk), .reset(reset), .start(start), .num_kij(num_kij),
        .len_nij(len_nij), .x_base(x_base), .w_base(w_base), .o_base(o_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One pass: pulse start, scramble config inputs, poke start mid-run, tally inst fields.
    task automatic run_pass(input int nk, input int len, input int xb, input int wb,
                            input int ob, input bit vld, input int abort_ex);
        int post;
        busy_cyc = 0; done_cnt = 0; done_cyc = -1; cen_low = 0;
        pmem_n = 0; pmem_first = -1; first_pmem = -1; pmem_bad = 0;
        xmem_n = 0; xmem_bad = 0; load_n = 0; exec_n = 0; last_exec = -1; first_rd = -1;
        omem_n = 0; omem_bad = 0; omem_last = -1; omem_288 = -1; first_omem = -1;
        @(negedge clk);
        num_kij = 4'(nk); len_nij = AW'(len);
        x_base = AW'(xb); w_base = AW'(wb); o_base = AW'(ob);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_kij = 4'hf; len_nij = AW'(1); x_base = '1; w_base = '1; o_base = '1;
        post = -1;
        for (int c = 0; c < 4000 && post != 0; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) busy_cyc++;
            if (!inst[50] || !inst[32] || !inst[19]) cen_low++;
            if (!inst[32]) begin
                if (pmem_first < 0) begin pmem_first = int'(inst[30:20]); first_pmem = c; end
                if (inst[30:20] != AW'(wb + pmem_n)) pmem_bad++;
                pmem_n++;
            end
            if (!inst[19]) begin
                if (len > 0 && inst[17:7] != AW'(xb + xmem_n % len)) xmem_bad++;
                xmem_n++;
            end
            if (inst[0] && inst[36]) load_n++;
            if (inst[1]) begin exec_n++; last_exec = c; end
            if (inst[6] && first_rd < 0) first_rd = c;
            if (!inst[50]) begin
                if (first_omem < 0) first_omem = c;
                if (omem_n == 288) omem_288 = int'(inst[48:38]);
                omem_last = int'(inst[48:38]);
                if (inst[48:38] != AW'(ob + omem_n) || inst[49]) omem_bad++;
                omem_n++;
            end
            if (abort_ex > 0 && exec_n == abort_ex) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_inst", inst, IDLE_W);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_no_done_pulse", done_cnt, 0);
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                return;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (post < 0) post = 4;
            end
            if (post > 0) post--;
            start       = (c == 50);
            ofifo_valid = vld && last_exec >= 0 && c == last_exec + 5;
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
        chk("pass_terminated", post == 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_inst", inst, IDLE_W);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_inst", inst, IDLE_W);

        // Single kij, len 36, zero bases: 2*8 + 2*10 + 3*36 + 35 + 2 = 181 busy cycles
        run_pass(1, 36, 0, 0, 0, 1'b0, 0);
        chk("t1_busy_cyc", busy_cyc, 181);
        chk("t1_done_cyc", done_cyc, 181);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_pmem_n", pmem_n, 8);
        chk("t1_pmem_addr", pmem_bad, 0);
        chk("t1_first_pmem_cyc", first_pmem, 1);
        chk("t1_load_n", load_n, 8);
        chk("t1_xmem_n", xmem_n, 36);
        chk("t1_xmem_addr", xmem_bad, 0);
        chk("t1_exec_n", exec_n, 36);
        chk("t1_omem_n", omem_n, 36);
        chk("t1_omem_addr", omem_bad, 0);
        chk("t1_omem_lag", first_omem - first_rd, 1);
        chk("t1_drain_gap", first_rd - last_exec, 36);
        chk("t1_idle_after", inst, IDLE_W);

        // Nine kij, o_base 100: last kij writes 100+8*36 = 388 .. 423
        run_pass(9, 36, 0, 0, 100, 1'b0, 0);
        chk("t2_omem_n", omem_n, 324);
        chk("t2_omem_addr", omem_bad, 0);
        chk("t2_last_kij_first", omem_288, 388);
        chk("t2_last_kij_last", omem_last, 423);
        chk("t2_pmem_n", pmem_n, 72);
        chk("t2_busy_cyc", busy_cyc, 1629);
        chk("t2_done_cnt", done_cnt, 1);

        // Degenerate passes: done right after start, no memory access
        run_pass(0, 36, 0, 0, 0, 1'b0, 0);
        chk("t3_done_cyc", done_cyc, 0);
        chk("t3_busy_cyc", busy_cyc, 0);
        chk("t3_cen_low", cen_low, 0);
        chk("t3_done_cnt", done_cnt, 1);
        run_pass(3, 0, 0, 0, 0, 1'b0, 0);
        chk("t3b_done_cyc", done_cyc, 0);
        chk("t3b_cen_low", cen_low, 0);

        // Reset mid-EXEC of kij 3, then a fresh pass restarts at kij 0
        run_pass(5, 36, 0, 0, 0, 1'b0, 3 * 36 + 10);
        run_pass(1, 4, 5, 16, 7, 1'b0, 0);
        chk("t4_pmem_first", pmem_first, 16);
        chk("t4_pmem_addr", pmem_bad, 0);
        chk("t4_xmem_addr", xmem_bad, 0);
        chk("t4_omem_last", omem_last, 10);
        chk("t4_busy_cyc", busy_cyc, 85);

        // ofifo_valid on drain cycle 5
        run_pass(1, 4, 0, 0, 0, 1'b1, 0);
        chk("t5_drain_gap", first_rd - last_exec, EXP_GAP_V);
        chk("t5_busy_cyc", busy_cyc, EXP_BUSY_V);
        chk("t5_omem_n", omem_n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
